sc_note_fetch_sched: RTL

//  Shares the single-port song note ROM among the per-lane note matchers. Each

---
 rtl/sc_note_fetch_sched.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sc_note_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module      : sc_note_fetch_sched
// Description : Shares a single-port song note ROM among the per-lane note
//               matchers. Each lane's request pulse is latched as pending,
//               lanes are served round-robin with one ROM access in flight,
//               and the fetched note time is handed to the lane together with
//               a one-cycle note_load pulse.
// Ports       : clk, rst_n           clock, asynchronous active-low reset
//               song_start           restart every lane at note index 0
//               lane_req             per-lane request pulses
//               rom_en/rom_addr      ROM read port, address {lane, index}
//               rom_data             ROM data, valid one cycle after rom_en
//               note_time            lane i next-note time at [18*i +: 18]
//               note_load            per-lane "note_time just updated" pulse
//               lane_done            sticky: lane returned END_MARK
//               busy                 FSM active or any request pending
//               req_drop             sticky: request lost to a pending lane
// Revision    : 1.0 - initial release
// ============================================================================
module sc_note_fetch_sched #(
  parameter int          NUM_LANES = 5,
  parameter int          LANE_W    = 3,
  parameter int          IDX_W     = 10,
  parameter logic [17:0] END_MARK  = 18'h3FFFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      song_start,
  input  logic [NUM_LANES-1:0]      lane_req,
  output logic                      rom_en,
  output logic [LANE_W+IDX_W-1:0]   rom_addr,
  input  logic [17:0]               rom_data,
  output logic [18*NUM_LANES-1:0]   note_time,
  output logic [NUM_LANES-1:0]      note_load,
  output logic [NUM_LANES-1:0]      lane_done,
  output logic                      busy,
  output logic                      req_drop
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t               state;
  logic [NUM_LANES-1:0] pending;
  logic [IDX_W-1:0]     ptr [NUM_LANES];
  logic [LANE_W-1:0]    rr_ptr;
  logic [LANE_W-1:0]    g;          // lane owning the in-flight access

  logic [NUM_LANES-1:0] cap_mask;
  logic                 grant_found;
  logic [LANE_W-1:0]    grant_lane;
  logic [LANE_W:0]      cand_sum;
  logic                 collide;

  // The lane being captured this cycle; its pending bit clears unless a new
  // request for it arrives in the same cycle (set beats clear).
  always_comb begin
    cap_mask = '0;
    if (state == S_CAPTURE) cap_mask[g] = 1'b1;
  end

  assign collide = |(lane_req & pending & ~cap_mask);

  // Round-robin search: scan offsets from the far end down so the lane closest
  // to rr_ptr (wrapping) is the one left in grant_lane.
  always_comb begin
    grant_found = 1'b0;
    grant_lane  = '0;
    cand_sum    = '0;
    for (int off = NUM_LANES - 1; off >= 0; off--) begin
      cand_sum = {1'b0, rr_ptr} + (LANE_W+1)'(off);
      if (cand_sum >= (LANE_W+1)'(NUM_LANES))
        cand_sum = cand_sum - (LANE_W+1)'(NUM_LANES);
      if (pending[cand_sum[LANE_W-1:0]]) begin
        grant_found = 1'b1;
        grant_lane  = cand_sum[LANE_W-1:0];
      end
    end
  end

  assign busy = (state != S_IDLE) || (|pending);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pending   <= '0;
      for (int i = 0; i < NUM_LANES; i++) ptr[i] <= '0;
      note_time <= {NUM_LANES{END_MARK}};
      note_load <= '0;
      lane_done <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      req_drop  <= 1'b0;
      rr_ptr    <= '0;
      g         <= '0;
    end else if (song_start) begin
      // Abort any in-flight access; the ROM data it returns is never captured
      // because the FSM is back in IDLE.
      state     <= S_IDLE;
      pending   <= '1;
      for (int i = 0; i < NUM_LANES; i++) ptr[i] <= '0;
      note_time <= {NUM_LANES{END_MARK}};
      note_load <= '0;
      lane_done <= '0;
      rom_en    <= 1'b0;
      req_drop  <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      note_load <= '0;
      pending   <= (pending & ~cap_mask) | lane_req;
      if (collide) req_drop <= 1'b1;

      case (state)
        S_IDLE: begin
          if (grant_found) begin
            g        <= grant_lane;
            rom_addr <= {grant_lane, ptr[grant_lane]};
            rom_en   <= 1'b1;
            state    <= S_READ;
          end
        end
        S_READ: begin
          rom_en <= 1'b0;
          state  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          note_time[18*g +: 18] <= rom_data;
          note_load[g]          <= 1'b1;
          rr_ptr <= (g == LANE_W'(NUM_LANES - 1)) ? '0 : g + LANE_W'(1);
          if (rom_data == END_MARK)
            lane_done[g] <= 1'b1;
          else if (ptr[g] != '1)
            ptr[g] <= ptr[g] + IDX_W'(1);  // saturated lane re-reads last entry
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
